mux_tx: RTL and testbench

MUX_TX -- requirements
Module: mux_tx

---
 rtl/mux_tx.sv | 65 ++++++
 tb/tb_mux_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mux_tx.sv
// mux_tx: merges two byte lanes through DEPTH-byte FIFOs into one registered stream in strict lane 0/1 alternation (clk_2f, reset, data_in_n/valid_in_n/ready_n in, data_mux/valid_mux/idle out)
module mux_tx #(
  parameter int DEPTH = 4
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_0,
  output logic       ready_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_1,
  output logic       ready_1,
  output logic [7:0] data_mux,
  output logic       valid_mux,
  output logic       idle
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [7:0] din [2];
  logic [7:0] head [2];
  logic [1:0] vin, rdy, push, pop, empty;
  logic sel;
  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign vin = {valid_in_1, valid_in_0};
  assign push = vin & rdy;
  assign ready_0 = rdy[0];
  assign ready_1 = rdy[1];
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign rdy[l] = cnt < FULL;
    assign empty[l] = cnt == '0;
    assign pop[l] = (sel == 1'(l)) && !empty[l];
    assign head[l] = mem[rp];
    always_ff @(posedge clk_2f)
      if (!reset && push[l]) mem[wp] <= din[l];
    always_ff @(posedge clk_2f) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        wp <= wp + AW'(push[l]);
        rp <= rp + AW'(pop[l]);
        cnt <= cnt + {{AW{1'b0}}, push[l]} - {{AW{1'b0}}, pop[l]};
      end
    end
  end
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel <= 1'b0;
      valid_mux <= 1'b0;
      data_mux <= 8'h00;
    end else begin
      valid_mux <= pop[sel];
      if (pop[sel]) begin
        data_mux <= head[sel];
        sel <= ~sel;
      end
    end
  end
  assign idle = &empty && !valid_mux;
endmodule

// File: tb/tb_mux_tx.sv
// tb_mux_tx: scoreboard bench for mux_tx with per-lane expected queues and modelled alternation
module tb_mux_tx;
  localparam int DEPTH = 4;
  logic clk_2f = 0;
  logic reset = 1;
  logic [7:0] data_in_0 = 0, data_in_1 = 0;
  logic valid_in_0 = 0, valid_in_1 = 0;
  logic ready_0, ready_1, valid_mux, idle;
  logic [7:0] data_mux;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic msel = 0;
  int vectors = 0, miscompares = 0;
  mux_tx #(.DEPTH(DEPTH)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .data_in_0(data_in_0), .valid_in_0(valid_in_0), .ready_0(ready_0),
    .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_1(ready_1),
    .data_mux(data_mux), .valid_mux(valid_mux), .idle(idle)
  );
  always #5 clk_2f = ~clk_2f;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                       output logic a0, output logic a1);
    logic p;
    logic [7:0] b;
    @(negedge clk_2f);
    valid_in_0 = v0; data_in_0 = d0;
    valid_in_1 = v1; data_in_1 = d1;
    #1;
    chk("ready_0", ready_0, q0.size() < DEPTH);
    chk("ready_1", ready_1, q1.size() < DEPTH);
    a0 = v0 && q0.size() < DEPTH;
    a1 = v1 && q1.size() < DEPTH;
    p = msel ? q1.size() != 0 : q0.size() != 0;
    b = !p ? 8'h00 : msel ? q1[0] : q0[0];
    @(posedge clk_2f);
    #1;
    if (p) begin
      if (msel) void'(q1.pop_front());
      else void'(q0.pop_front());
      msel = ~msel;
    end
    if (a0) q0.push_back(d0);
    if (a1) q1.push_back(d1);
    chk("valid_mux", valid_mux, p);
    if (p) chk("data_mux", data_mux, b);
    chk("idle", idle, q0.size() == 0 && q1.size() == 0 && !p);
  endtask
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    logic a0, a1;
    cycle(v0, d0, v1, d1, a0, a1);
  endtask
  task automatic do_reset();
    @(negedge clk_2f);
    reset = 1; valid_in_0 = 1; valid_in_1 = 1; data_in_0 = 8'hEE; data_in_1 = 8'hEE;
    @(posedge clk_2f);
    #1;
    q0.delete(); q1.delete(); msel = 0;
    @(negedge clk_2f);
    reset = 0; valid_in_0 = 0; valid_in_1 = 0;
    #1;
    chk("rst_valid", valid_mux, 0);
    chk("rst_data", data_mux, 0);
    chk("rst_ready_0", ready_0, 1);
    chk("rst_ready_1", ready_1, 1);
    chk("rst_idle", idle, 1);
  endtask
  initial begin
    int i0, i1, cyc;
    logic a0, a1;
    do_reset();
    step(1, 8'hA0, 1, 8'hB0);
    step(0, 0, 0, 0);
    chk("alt_a0", data_mux, 8'hA0);
    step(0, 0, 0, 0);
    chk("alt_b0", data_mux, 8'hB0);
    step(0, 0, 0, 0);
    chk("alt_idle", idle, 1);
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    chk("starve_hold", valid_mux, 0);
    step(0, 0, 1, 8'h33);
    step(0, 0, 0, 0);
    chk("starve_33", data_mux, 8'h33);
    step(0, 0, 0, 0);
    chk("starve_22", data_mux, 8'h22);
    step(0, 0, 0, 0);
    do_reset();
    step(1, 8'h01, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) step(1, 8'h10 + 8'(k), 0, 0);
    chk("full_ready_0", ready_0, 0);
    step(1, 8'hFF, 0, 0);
    for (int k = 0; k < DEPTH; k++) step(0, 0, 1, 8'h70 + 8'(k));
    for (int k = 0; k < 3 * DEPTH; k++) step(0, 0, 0, 0);
    chk("full_drained", idle, 1);
    i0 = 0; i1 = 0; cyc = 0;
    while ((i0 < 48 || i1 < 48 || !idle) && cyc < 400) begin
      cycle(i0 < 48, 8'(i0), i1 < 48, 8'h80 + 8'(i1), a0, a1);
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    chk("wrap_done", {i0[15:0], i1[15:0]}, {16'd48, 16'd48});
    chk("wrap_idle", idle, 1);
    step(1, 8'hC0, 1, 8'hD0);
    step(1, 8'hC1, 1, 8'hD1);
    step(1, 8'hC2, 1, 8'hD2);
    do_reset();
    step(0, 0, 1, 8'h99);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_lane1_wait", valid_mux, 0);
    step(1, 8'h55, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_first_lane0", data_mux, 8'h55);
    step(0, 0, 0, 0);
    chk("rst_then_lane1", data_mux, 8'h99);
    step(0, 0, 0, 0);
    step(1, 8'h44, 0, 0);
    step(1, 8'h5A, 0, 0);
    chk("pp_44", data_mux, 8'h44);
    chk("pp_ready_0", ready_0, 1);
    step(0, 0, 0, 0);
    chk("pp_stall", valid_mux, 0);
    step(0, 0, 1, 8'h66);
    step(0, 0, 0, 0);
    chk("pp_66", data_mux, 8'h66);
    step(0, 0, 0, 0);
    chk("pp_5a", data_mux, 8'h5A);
    step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
